// File: rtl/banco_registradores_pkg.sv
// rtl/banco_registradores_pkg.sv - shared defaults for the register file datapath
package banco_registradores_pkg;

  // Datapath defaults shared by the array and the scoreboard
  localparam int          LARGURA_PADRAO      = 32;
  localparam int          PROFUNDIDADE_PADRAO = 32;
  localparam int          NLEIT_PADRAO        = 3;
  localparam int          SP_INDICE_PADRAO    = 29;
  localparam logic [31:0] SP_INICIAL_PADRAO   = 32'h0000_00FC;

endpackage

// File: rtl/placar_registradores.sv
// rtl/placar_registradores.sv - reservation scoreboard with pending flags and live count
module placar_registradores
  import banco_registradores_pkg::*;
#(
  parameter  int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter  int NLEIT        = NLEIT_PADRAO,
  parameter  int BYPASS       = 1,
  localparam int AW           = $clog2(PROFUNDIDADE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NLEIT*AW-1:0] end_leitura,
  input  logic                escreve_R,
  input  logic [AW-1:0]       endereco_E,
  input  logic                reserva_v,
  input  logic [AW-1:0]       reserva_end,
  output logic [NLEIT-1:0]    pendente,
  output logic [AW:0]         num_pendentes
);

  localparam logic [AW:0] UM = (AW+1)'(1);

  logic [PROFUNDIDADE-1:0] bits_q, bits_d;
  logic [AW:0]             num_q, num_d;
  logic                    limpa, marca, inc, dec;

  // Next scoreboard state: the write clears first so a same-register reservation wins
  always_comb begin
    limpa  = escreve_R && (endereco_E != '0);
    marca  = reserva_v && (reserva_end != '0);
    bits_d = bits_q;
    if (limpa) bits_d[endereco_E] = 1'b0;
    if (marca) bits_d[reserva_end] = 1'b1;
    // Count only real transitions of a bit, so re-reserving or reserve+write of one reg is net 0
    inc   = marca && !bits_q[reserva_end];
    dec   = limpa && bits_q[endereco_E] && !(marca && (reserva_end == endereco_E));
    num_d = num_q;
    if (inc && !dec)      num_d = num_q + UM;
    else if (dec && !inc) num_d = num_q - UM;
  end

  // Scoreboard bits and population count share one edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bits_q <= '0;
      num_q  <= '0;
    end else begin
      bits_q <= bits_d;
      num_q  <= num_d;
    end
  end

  assign num_pendentes = num_q;

  // A forwarded write already satisfies the reader, so it is no longer pending
  for (genvar p = 0; p < NLEIT; p++) begin : g_pend
    logic [AW-1:0] end_p;
    assign end_p       = end_leitura[p*AW +: AW];
    assign pendente[p] = (end_p != '0) && bits_q[end_p]
                         && !((BYPASS != 0) && limpa && (end_p == endereco_E));
  end

endmodule

// File: rtl/banco_registradores.sv
// rtl/banco_registradores.sv - multi-port register file with forwarding and reservation scoreboard
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter  int                 LARGURA      = LARGURA_PADRAO,
  parameter  int                 PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter  int                 NLEIT        = NLEIT_PADRAO,
  parameter  int                 BYPASS       = 1,
  parameter  int                 SP_INDICE    = SP_INDICE_PADRAO,
  parameter  logic [LARGURA-1:0] SP_INICIAL   = LARGURA'(SP_INICIAL_PADRAO),
  localparam int                 AW           = $clog2(PROFUNDIDADE)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NLEIT*AW-1:0]      end_leitura,
  output logic [NLEIT*LARGURA-1:0] dados_leitura,
  input  logic                     escreve_R,
  input  logic [AW-1:0]            endereco_E,
  input  logic [LARGURA-1:0]       dados,
  input  logic                     reserva_v,
  input  logic [AW-1:0]            reserva_end,
  output logic [NLEIT-1:0]         pendente,
  output logic [AW:0]              num_pendentes
);

  logic [LARGURA-1:0] regs_q [PROFUNDIDADE];
  logic               escrita_ok;

  assign escrita_ok = escreve_R && (endereco_E != '0);

  // Register array: async reset to zero except the stack pointer; r0 is never written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < PROFUNDIDADE; k++) begin
        regs_q[k] <= (k == SP_INDICE) ? SP_INICIAL : '0;
      end
    end else if (escrita_ok) begin
      regs_q[endereco_E] <= dados;
    end
  end

  // Combinational read ports: r0 is hardwired zero, optional same-cycle forwarding
  for (genvar p = 0; p < NLEIT; p++) begin : g_porta
    logic [AW-1:0] end_p;
    logic          encaminha;
    assign end_p     = end_leitura[p*AW +: AW];
    assign encaminha = (BYPASS != 0) && escrita_ok && (end_p == endereco_E);
    assign dados_leitura[p*LARGURA +: LARGURA] =
        (end_p == '0) ? '0 : (encaminha ? dados : regs_q[end_p]);
  end

  placar_registradores #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .NLEIT        (NLEIT),
    .BYPASS       (BYPASS)
  ) u_placar (
    .clock         (clock),
    .reset         (reset),
    .end_leitura   (end_leitura),
    .escreve_R     (escreve_R),
    .endereco_E    (endereco_E),
    .reserva_v     (reserva_v),
    .reserva_end   (reserva_end),
    .pendente      (pendente),
    .num_pendentes (num_pendentes)
  );

endmodule

// File: tb/tb_banco_registradores.sv
// tb/tb_banco_registradores.sv - scoreboard bench for banco_registradores, forwarding on and off
module tb_banco_registradores;

  localparam int AW = 5;
  localparam int W  = 32;
  localparam int NL = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [NL*AW-1:0] end_leitura;
  logic [NL*W-1:0]  dl_a, dl_b;
  logic             escreve_R;
  logic [AW-1:0]    endereco_E;
  logic [W-1:0]     dados;
  logic             reserva_v;
  logic [AW-1:0]    reserva_end;
  logic [NL-1:0]    pend_a, pend_b;
  logic [AW:0]      num_a, num_b;

  int n_testes = 0;
  int n_falhas = 0;

  typedef struct {
    string       tag;
    int          tipo;
    int          idx;
    logic [31:0] esp;
  } item_t;

  item_t fila[$];

  logic [31:0] m_reg [32];
  logic [31:0] m_bits;

  always #5 clock = ~clock;

  banco_registradores #(.BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .end_leitura(end_leitura), .dados_leitura(dl_a),
    .escreve_R(escreve_R), .endereco_E(endereco_E), .dados(dados),
    .reserva_v(reserva_v), .reserva_end(reserva_end), .pendente(pend_a), .num_pendentes(num_a)
  );

  banco_registradores #(.BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .end_leitura(end_leitura), .dados_leitura(dl_b),
    .escreve_R(escreve_R), .endereco_E(endereco_E), .dados(dados),
    .reserva_v(reserva_v), .reserva_end(reserva_end), .pendente(pend_b), .num_pendentes(num_b)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: obtido %h esperado %h", tag, obs, esp);
    end
  endtask

  // tipo: 0/1 data of dut_a/dut_b, 2/3 pendente, 4/5 num_pendentes
  function automatic logic [31:0] observado(input int tipo, input int idx);
    case (tipo)
      0:       return dl_a[idx*W +: W];
      1:       return dl_b[idx*W +: W];
      2:       return {31'b0, pend_a[idx]};
      3:       return {31'b0, pend_b[idx]};
      4:       return {26'b0, num_a};
      default: return {26'b0, num_b};
    endcase
  endfunction

  task automatic prever(input string tag, input int tipo, input int idx, input logic [31:0] esp);
    item_t it;
    it.tag = tag; it.tipo = tipo; it.idx = idx; it.esp = esp;
    fila.push_back(it);
  endtask

  task automatic prever2(input string tag, input int base, input int idx, input logic [31:0] esp);
    prever({tag, "_a"}, base, idx, esp);
    prever({tag, "_b"}, base + 1, idx, esp);
  endtask

  task automatic drena();
    item_t it;
    #2;
    while (fila.size() > 0) begin
      it = fila.pop_front();
      verifica(it.tag, observado(it.tipo, it.idx), it.esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ocioso();
    escreve_R = 1'b0; endereco_E = '0; dados = '0;
    reserva_v = 1'b0; reserva_end = '0;
  endtask

  task automatic le(input int a0, input int a1, input int a2);
    end_leitura = {5'(a2), 5'(a1), 5'(a0)};
  endtask

  task automatic escreve(input int a, input logic [31:0] d);
    escreve_R = 1'b1; endereco_E = 5'(a); dados = d;
  endtask

  task automatic reserva(input int a);
    reserva_v = 1'b1; reserva_end = 5'(a);
  endtask

  initial begin
    reset = 1'b1;
    ocioso();
    le(0, 29, 5);
    // traffic during reset must be discarded
    escreve(7, 32'hBAD0_BAD0);
    reserva(7);
    repeat (3) @(posedge clock);
    @(negedge clock);
    ocioso();
    reset = 1'b0;

    prever2("rst_r0", 0, 0, 32'h0);
    prever2("rst_sp", 0, 1, 32'h0000_00FC);
    prever2("rst_r5", 0, 2, 32'h0);
    prever2("rst_num", 4, 0, 32'h0);
    prever2("rst_pend", 2, 1, 32'h0);
    drena();
    le(7, 0, 0);
    prever2("rst_w_desc", 0, 0, 32'h0);
    prever2("rst_res_desc", 2, 0, 32'h0);
    drena();

    // r0 is immune to writes, including forwarding
    le(0, 0, 0);
    escreve(0, 32'hDEAD_BEEF);
    prever2("w0_mesmo", 0, 0, 32'h0);
    drena();
    ciclo(); ocioso();
    prever2("w0_le", 0, 0, 32'h0);
    drena();
    escreve(7, 32'h1234_5678);
    ciclo(); ocioso();
    le(0, 0, 7);
    prever2("r7", 0, 2, 32'h1234_5678);
    drena();

    // forwarding versus old value
    escreve(3, 32'h1111_0000);
    ciclo();
    le(0, 3, 0);
    escreve(3, 32'hA5A5_A5A5);
    prever("byp_a", 0, 1, 32'hA5A5_A5A5);
    prever("byp_b", 1, 1, 32'h1111_0000);
    drena();
    ciclo(); ocioso();
    prever2("byp_dep", 0, 1, 32'hA5A5_A5A5);
    drena();

    // reserve then satisfy r8
    le(8, 0, 0);
    reserva(8);
    prever2("res8_ant", 2, 0, 32'h0);
    prever2("res8_num_ant", 4, 0, 32'h0);
    drena();
    ciclo(); ocioso();
    prever2("res8_pend", 2, 0, 32'h1);
    prever2("res8_num", 4, 0, 32'h1);
    drena();
    escreve(8, 32'h55);
    prever("w8_pend_a", 2, 0, 32'h0);
    prever("w8_pend_b", 3, 0, 32'h1);
    prever("w8_dado_a", 0, 0, 32'h55);
    prever("w8_dado_b", 1, 0, 32'h0);
    prever2("w8_num_mesmo", 4, 0, 32'h1);
    drena();
    ciclo(); ocioso();
    prever2("w8_num", 4, 0, 32'h0);
    prever2("w8_pend_dep", 2, 0, 32'h0);
    prever2("w8_dado_dep", 0, 0, 32'h55);
    drena();

    // reserve and write the same register in one cycle
    le(0, 9, 10);
    reserva(9);
    escreve(9, 32'h11);
    ciclo(); ocioso();
    prever2("r9_dado", 0, 1, 32'h11);
    prever2("r9_pend", 2, 1, 32'h1);
    prever2("r9_num", 4, 0, 32'h1);
    drena();
    reserva(9);
    ciclo(); ocioso();
    prever2("r9_rerres", 4, 0, 32'h1);
    drena();
    escreve(9, 32'h22);
    reserva(10);
    ciclo(); ocioso();
    prever2("r9r10_num", 4, 0, 32'h1);
    prever2("r9_limpo", 2, 1, 32'h0);
    prever2("r10_pend", 2, 2, 32'h1);
    drena();
    escreve(10, 32'h0);
    ciclo(); ocioso();
    prever2("r10_num", 4, 0, 32'h0);
    drena();

    // reset in the middle of a reservation burst
    escreve(29, 32'h0000_1000);
    ciclo(); ocioso();
    le(4, 5, 29);
    prever2("sp_w", 0, 2, 32'h0000_1000);
    drena();
    reserva(4);
    ciclo();
    reserva(5);
    ciclo();
    reserva(6);
    prever2("burst_num", 4, 0, 32'h2);
    prever2("burst_p4", 2, 0, 32'h1);
    prever2("burst_p5", 2, 1, 32'h1);
    drena();
    reset = 1'b1;
    prever2("arst_num", 4, 0, 32'h0);
    prever2("arst_p4", 2, 0, 32'h0);
    prever2("arst_p5", 2, 1, 32'h0);
    prever2("arst_sp", 0, 2, 32'h0000_00FC);
    drena();
    ocioso();
    repeat (2) ciclo();
    reset = 1'b0;

    // randomized traffic checked against a reference model
    for (int k = 0; k < 32; k++) m_reg[k] = '0;
    m_reg[29] = 32'h0000_00FC;
    m_bits    = '0;
    for (int n = 0; n < 300; n++) begin
      int          a [3];
      logic        we, rv;
      int          wa, ra;
      logic [31:0] wd, esp_a, esp_b;
      for (int p = 0; p < 3; p++) a[p] = int'($urandom_range(0, 15));
      we = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 2) == 0);
      wa = int'($urandom_range(0, 15));
      ra = int'($urandom_range(0, 15));
      wd = $urandom;
      le(a[0], a[1], a[2]);
      escreve_R = we; endereco_E = 5'(wa); dados = wd;
      reserva_v = rv; reserva_end = 5'(ra);
      for (int p = 0; p < 3; p++) begin
        logic fwd;
        fwd   = we && (wa != 0) && (a[p] == wa);
        esp_b = (a[p] == 0) ? 32'h0 : m_reg[a[p]];
        esp_a = fwd ? wd : esp_b;
        prever("ale_dado_a", 0, p, esp_a);
        prever("ale_dado_b", 1, p, esp_b);
        prever("ale_pend_a", 2, p, {31'b0, (a[p] != 0) && m_bits[a[p]] && !fwd});
        prever("ale_pend_b", 3, p, {31'b0, (a[p] != 0) && m_bits[a[p]]});
      end
      prever2("ale_num", 4, 0, 32'($countones(m_bits)));
      drena();
      if (we && wa != 0) begin
        m_reg[wa]  = wd;
        m_bits[wa] = 1'b0;
      end
      if (rv && ra != 0) m_bits[ra] = 1'b1;
      ciclo();
    end
    ocioso();

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
